// File: rtl/multu_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier (multu_seq).
// Holds the default operand width, the derived product width, the control
// state encoding and the fixed operation latency.
package multu_seq_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_PROD_W = 2 * DEF_WIDTH;
  localparam int DEF_CNT_W  = 6;

  // Start edge to product-valid edge, in clock edges; independent of operand values.
  localparam int LATENCY = DEF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_seq_if.sv
// Handshake/data bundle between the EX-stage requester and multu_seq.
// Optional signed support is enabled with macro MULTU_SEQ_SIGNED_EN,
// which adds the is_signed request qualifier.
//
// Handshake: the requester raises start for one cycle with a/b (and
// is_signed) valid in the same cycle; the request is accepted only when
// busy=0. busy stays high while iterating, done pulses for one cycle when
// product has just been updated, and product is held until the next
// completion. dbg_state mirrors the control FSM state for observation.
interface multu_seq_if import multu_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef MULTU_SEQ_SIGNED_EN
  logic                 is_signed;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  state_t               dbg_state;

`ifdef MULTU_SEQ_SIGNED_EN
  modport master (output start, a, b, is_signed,
                  input  busy, done, product, dbg_state);
  modport slave  (input  start, a, b, is_signed,
                  output busy, done, product, dbg_state);
`else
  modport master (output start, a, b,
                  input  busy, done, product, dbg_state);
  modport slave  (input  start, a, b,
                  output busy, done, product, dbg_state);
`endif

endinterface

// File: rtl/multu_step.sv
// One shift-add iteration of the multiplier datapath. Purely combinational
// so several copies can later be chained to retire more bits per cycle.
// acc holds {partial_high, remaining_multiplier_bits}; the low bit decides
// whether the multiplicand is added into the high half before shifting.
module multu_step import multu_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [WIDTH:0] w_sum;

  // Conditional add with the carry kept, then a logical right shift by one.
  always_comb begin
    w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
    if (i_acc[0]) begin
      w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand};
    end
    o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_seq.sv
// Multi-cycle shift-add MULTU unit for the EX stage. Accepts two operands
// on a start pulse, iterates WIDTH cycles, then loads the 2*WIDTH-bit
// product and pulses done. product is held between operations so the HI/LO
// write path always sees a stable value.
// Optional macro MULTU_SEQ_SIGNED_EN adds signed multiply via is_signed:
// magnitudes are iterated and the result is negated at the product load.
module multu_seq import multu_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  multu_seq_if.slave    bus
);

  localparam int PW = 2 * WIDTH;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [PW-1:0]        r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic [PW-1:0]        r_product;

  logic [PW-1:0]        w_acc_next;
  logic [PW-1:0]        w_final;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_last;

`ifdef MULTU_SEQ_SIGNED_EN
  logic                 r_neg;
  logic                 w_a_neg;
  logic                 w_b_neg;

  // Signed requests iterate on magnitudes; the most negative value's
  // magnitude still fits in WIDTH unsigned bits.
  always_comb begin
    w_a_neg = bus.is_signed & bus.a[WIDTH-1];
    w_b_neg = bus.is_signed & bus.b[WIDTH-1];
    w_a_mag = w_a_neg ? (-bus.a) : bus.a;
    w_b_mag = w_b_neg ? (-bus.b) : bus.b;
    w_final = r_neg ? (-w_acc_next) : w_acc_next;
  end
`else
  // Unsigned only: operands are used as-is and the final acc is the product.
  always_comb begin
    w_a_mag = bus.a;
    w_b_mag = bus.b;
    w_final = w_acc_next;
  end
`endif

  multu_step #(.WIDTH(WIDTH)) u_step (
    .i_acc      (r_acc),
    .i_mcand    (r_mcand),
    .o_acc_next (w_acc_next)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM and datapath registers; all outputs except busy are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef MULTU_SEQ_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_cnt   <= '0;
            r_state <= ST_RUN;
`ifdef MULTU_SEQ_SIGNED_EN
            r_neg   <= w_a_neg ^ w_b_neg;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // start is ignored here: operands are not relatched mid-operation.
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_product <= w_final;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.product   = r_product;
  assign bus.dbg_state = r_state;

endmodule
